// File: rtl/test_checker.sv
// End-of-test detector and result-memory scanner.
// Counts cycles, waits for the end code, then compares results to golden.
module test_checker #(
  parameter int                ADDR_W     = 14,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] END_ADDR   = 'h3fff,
  parameter logic [DATA_W-1:0] END_CODE   = {DATA_W{1'b1}},
  parameter logic [ADDR_W-1:0] TEST_START = 'h2000,
  parameter int                NUM_WORDS  = 16,
  parameter int                MAX_CYCLES = 150000,
  parameter int                CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mon_we,
  input  logic [DATA_W/8-1:0] mon_be,
  input  logic [ADDR_W-1:0]   mon_addr,
  input  logic [DATA_W-1:0]   mon_wdata,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [11:0]         gold_idx,
  input  logic [DATA_W-1:0]   gold_data,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [11:0]         first_err_idx,
  output logic                first_err_vld,
  output logic [CNT_W-1:0]    cycle_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [11:0]      LAST_IDX = 12'(NUM_WORDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic                r_timeout;
  logic                r_rd_en;
  logic [11:0]         r_idx;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_cmp_vld;
  logic [11:0]         r_cmp_idx;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_first_vld;
  logic [11:0]         r_first_idx;
  logic                r_done;
  logic                r_pass;

  logic                w_run;
  logic                w_scan;
  logic                w_end_evt;
  logic                w_tmo_hit;
  logic                w_go_scan;
  logic                w_tmo_fire;
  logic                w_mismatch;
  logic                w_last_cmp;

  assign w_end_evt  = mon_we && (&mon_be) &&
                      (mon_addr == END_ADDR) &&
                      (mon_wdata == END_CODE);
  assign w_tmo_hit  = (r_cycle_cnt == TMO_LIM);
  assign w_go_scan  = w_run && (w_end_evt || w_tmo_hit);
  assign w_tmo_fire = w_run && w_tmo_hit && !w_end_evt;
  assign w_mismatch = r_cmp_vld && (rd_data != gold_data);
  assign w_last_cmp = r_cmp_vld && (r_cmp_idx == LAST_IDX);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  // next-state logic: end code (or timeout) starts the scan,
  // the final compare finishes it; DONE holds until reset
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_end_evt || w_tmo_hit) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last_cmp) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // state decode
  always_comb begin
    w_run  = 1'b0;
    w_scan = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN):  w_run  = 1'b1;
      (r_state == S_SCAN): w_scan = 1'b1;
      default: ;
    endcase
  end

  // cycle counter runs only in RUN; the end edge itself is not counted,
  // while the timeout edge is, so a timeout reports MAX_CYCLES
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_run && !w_end_evt && (r_cycle_cnt != CNT_MAX))
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_tmo_fire)
        r_timeout <= 1'b1;
    end
  end

  // read issue: one word per cycle from TEST_START, address wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_en   <= 1'b0;
      r_idx     <= '0;
      r_rd_addr <= TEST_START;
    end else if (w_go_scan) begin
      r_rd_en   <= 1'b1;
      r_idx     <= '0;
      r_rd_addr <= TEST_START;
    end else if (r_rd_en) begin
      if (r_idx == LAST_IDX) begin
        r_rd_en <= 1'b0;
      end else begin
        r_idx     <= r_idx + 12'd1;
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end
    end
  end

  // compare pipe: data returns one cycle after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmp_vld   <= 1'b0;
      r_cmp_idx   <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_cmp_vld <= r_rd_en;
      r_cmp_idx <= r_idx;
      if (w_mismatch) begin
        if (r_err_cnt != CNT_MAX)
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_cmp_idx;
        end
      end
    end
  end

  // verdict on the last compare, including that compare's outcome
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_scan && w_last_cmp) begin
      r_done <= 1'b1;
      r_pass <= (r_err_cnt == '0) && !w_mismatch && !r_timeout;
    end
  end

  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign gold_idx      = r_idx;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign first_err_vld = r_first_vld;
  assign cycle_cnt     = r_cycle_cnt;

endmodule
